// File: rtl/cpu_parameters.sv
// Shared CPU-wide constants and typedefs for the register file and its clients.
package cpu_parameters;

    localparam int unsigned xlen = 32;
    localparam int unsigned NregDefault = 32;
    localparam int unsigned TagwDefault = 4;

    typedef logic [$clog2(NregDefault)-1:0] reg_ad_t;
    typedef logic [TagwDefault-1:0]         reg_tag_t;

endpackage

// File: rtl/regfile_write_select.sv
// Resolves all write ports against one register: accept check plus highest-index-wins data pick.
module regfile_write_select #(
    parameter int unsigned NWRITE = 2,
    parameter int unsigned XLEN   = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned TAGW   = 4,
    parameter int unsigned IDX    = 1
) (
    input  logic [NWRITE-1:0]           w_valid,
    input  logic [NWRITE-1:0][AW-1:0]   w_ad,
    input  logic [NWRITE-1:0][TAGW-1:0] w_tag,
    input  logic [NWRITE-1:0][XLEN-1:0] w_data,
    input  logic                        cur_busy,
    input  logic [TAGW-1:0]             cur_tag,
    output logic                        we,
    output logic [XLEN-1:0]             wdata
);

    // Ascending loop so later (higher-index) ports override earlier ones.
    always_comb begin
        we    = 1'b0;
        wdata = '0;
        for (int j = 0; j < int'(NWRITE); j++) begin
            if (w_valid[j] && (w_ad[j] == AW'(IDX)) && cur_busy && (w_tag[j] == cur_tag)) begin
                we    = 1'b1;
                wdata = w_data[j];
            end
        end
    end

endmodule

// File: rtl/scoreboard_regfile.sv
// Multi-port register file with a per-register producer tag; stale writebacks are dropped.
module scoreboard_regfile
    import cpu_parameters::*;
#(
    parameter int unsigned XLEN   = xlen,
    parameter int unsigned NREG   = NregDefault,
    parameter int unsigned NREAD  = 2,
    parameter int unsigned NWRITE = 2,
    parameter int unsigned TAGW   = TagwDefault,
    parameter int unsigned BYPASS = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NWRITE-1:0]                     w_valid,
    input  logic [NWRITE-1:0][$clog2(NREG)-1:0]   w_ad,
    input  logic [NWRITE-1:0][TAGW-1:0]           w_tag,
    input  logic [NWRITE-1:0][XLEN-1:0]           w_data,
    input  logic [NREAD-1:0]                      r_valid,
    input  logic [NREAD-1:0][$clog2(NREG)-1:0]    r_ad,
    output logic [NREAD-1:0][XLEN-1:0]            r_data,
    output logic [NREAD-1:0]                      r_busy,
    output logic                                  r_v,
    input  logic                                  alloc_valid,
    input  logic [$clog2(NREG)-1:0]               alloc_ad,
    input  logic [TAGW-1:0]                       alloc_tag,
    input  logic                                  flush,
    output logic [$clog2(NREG):0]                 busy_cnt
);

    localparam int unsigned AW = $clog2(NREG);

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic [TAGW-1:0] tag_q [1:NREG-1];
    logic [TAGW-1:0] tag_d [1:NREG-1];
    logic [AW:0]     cnt_d;

    logic [NREG-1:0] we;
    logic [XLEN-1:0] wd [NREG];

    assign we[0] = 1'b0;
    assign wd[0] = '0;

    for (genvar r = 1; r < NREG; r++) begin : g_wsel
        regfile_write_select #(
            .NWRITE (NWRITE),
            .XLEN   (XLEN),
            .AW     (AW),
            .TAGW   (TAGW),
            .IDX    (r)
        ) u_wsel (
            .w_valid  (w_valid),
            .w_ad     (w_ad),
            .w_tag    (w_tag),
            .w_data   (w_data),
            .cur_busy (busy_q[r]),
            .cur_tag  (tag_q[r]),
            .we       (we[r]),
            .wdata    (wd[r])
        );
    end

    // Flush beats alloc, alloc beats a completing write.
    always_comb begin
        busy_d    = '0;
        cnt_d     = '0;
        for (int r = 1; r < int'(NREG); r++) begin
            busy_d[r] = busy_q[r];
            tag_d[r]  = tag_q[r];
            if (flush) begin
                busy_d[r] = 1'b0;
            end else if (alloc_valid && (alloc_ad == AW'(r))) begin
                busy_d[r] = 1'b1;
                tag_d[r]  = alloc_tag;
            end else if (we[r]) begin
                busy_d[r] = 1'b0;
            end
            cnt_d = cnt_d + (AW+1)'(busy_d[r]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            busy_cnt <= '0;
            for (int r = 0; r < int'(NREG); r++) regs_q[r] <= '0;
            for (int r = 1; r < int'(NREG); r++) tag_q[r] <= '0;
        end else begin
            busy_q   <= busy_d;
            busy_cnt <= cnt_d;
            for (int r = 1; r < int'(NREG); r++) begin
                tag_q[r] <= tag_d[r];
                if (we[r]) regs_q[r] <= wd[r];
            end
        end
    end

    always_comb begin
        r_data = '0;
        r_busy = '0;
        for (int i = 0; i < int'(NREAD); i++) begin
            if (r_valid[i]) begin
                r_data[i] = regs_q[r_ad[i]];
                r_busy[i] = busy_q[r_ad[i]];
                if ((BYPASS != 0) && we[r_ad[i]]) begin
                    r_data[i] = wd[r_ad[i]];
                    r_busy[i] = 1'b0;
                end
            end
        end
    end

    // Invalid ports already report r_busy=0, so a plain AND covers them.
    assign r_v = &(~r_busy);

endmodule
